// File: rtl/branch_update_queue.sv
// Update side of the branch predictor: queues resolved branch outcomes from EX and
// drains them one per cycle into the predictor write port, with hazard, mispredict and stats outputs.
module branch_update_queue #(
    parameter int entry_num  = 256,
    parameter int addr_width = $clog2(entry_num),
    parameter int fifo_depth = 4,
    parameter int cnt_width  = 16
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  branch_resolve_ex,
    input  logic [addr_width-1:0] branch_idx_ex,
    input  logic                  branch_taken_ex,
    input  logic                  branch_pred_ex,
    input  logic                  pred_valid_ex,
    input  logic                  predictor_hold,
    input  logic [addr_width-1:0] predictor_raddr,
    input  logic                  stats_clr,
    output logic                  upd_ready,
    output logic                  predictor_wen,
    output logic [addr_width-1:0] predictor_waddr,
    output logic                  predictor_wtaken,
    output logic                  raw_hazard,
    output logic                  mispredict,
    output logic                  overflow_err,
    output logic [cnt_width-1:0]  branch_cnt,
    output logic [cnt_width-1:0]  mispred_cnt
);
    localparam int SW = $clog2(fifo_depth);
    localparam int PW = SW + 1;
    localparam logic [PW-1:0] DEPTH = PW'(fifo_depth);

    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_count;
    logic [addr_width-1:0] r_idx [fifo_depth];
    logic [fifo_depth-1:0] r_tkn;

    logic          w_push;
    logic          w_pop;
    logic          w_mis;
    logic          w_hit;
    logic [SW-1:0] w_off;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == DEPTH - PW'(1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (&v) ? v : v + cnt_width'(1);
    endfunction

    // Readiness looks only at registered occupancy, never at a same-cycle pop.
    assign upd_ready        = (r_count != DEPTH);
    assign predictor_wen    = (r_count != '0) && !predictor_hold;
    assign predictor_waddr  = r_idx[r_rptr[SW-1:0]];
    assign predictor_wtaken = r_tkn[r_rptr[SW-1:0]];

    assign w_push = branch_resolve_ex && upd_ready;
    assign w_pop  = predictor_wen;
    assign w_mis  = w_push && pred_valid_ex && (branch_pred_ex != branch_taken_ex);

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int k = 0; k < fifo_depth; k++) begin
            w_off = SW'(k) - r_rptr[SW-1:0];
            if (({1'b0, w_off} < r_count) && (r_idx[k] == predictor_raddr))
                w_hit = 1'b1;
        end
    end
    assign raw_hazard = w_hit;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_tkn   <= '0;
            for (int i = 0; i < fifo_depth; i++) r_idx[i] <= '0;
        end else begin
            if (w_push) begin
                r_idx[r_wptr[SW-1:0]] <= branch_idx_ex;
                r_tkn[r_wptr[SW-1:0]] <= branch_taken_ex;
                r_wptr                <= next_ptr(r_wptr);
            end
            if (w_pop) r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            mispredict   <= 1'b0;
            overflow_err <= 1'b0;
            branch_cnt   <= '0;
            mispred_cnt  <= '0;
        end else begin
            mispredict <= w_mis;
            if (branch_resolve_ex && !upd_ready) overflow_err <= 1'b1;
            // Clear wins over a same-cycle increment.
            if (stats_clr) begin
                branch_cnt  <= '0;
                mispred_cnt <= '0;
            end else begin
                if (w_push) branch_cnt  <= sat_inc(branch_cnt);
                if (w_mis)  mispred_cnt <= sat_inc(mispred_cnt);
            end
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue: table vectors, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_branch_update_queue;
    logic       cpu_clk = 1'b0;
    logic       cpu_rstn;
    logic       res, tkn, pred, pv, hold, clr;
    logic [7:0] idx, raddr;

    logic        upd_ready, wen, wtaken, hazard, misp, ovf;
    logic [7:0]  waddr;
    logic [15:0] bcnt, mcnt;
    logic        upd_ready2, wen2, wtaken2, hazard2, misp2, ovf2;
    logic [7:0]  waddr2;
    logic [1:0]  bcnt2, mcnt2;

    always #5 cpu_clk = ~cpu_clk;

    branch_update_queue #(.entry_num(256), .fifo_depth(4), .cnt_width(16)) u_dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .branch_resolve_ex(res), .branch_idx_ex(idx),
        .branch_taken_ex(tkn), .branch_pred_ex(pred), .pred_valid_ex(pv), .predictor_hold(hold),
        .predictor_raddr(raddr), .stats_clr(clr), .upd_ready(upd_ready), .predictor_wen(wen),
        .predictor_waddr(waddr), .predictor_wtaken(wtaken), .raw_hazard(hazard),
        .mispredict(misp), .overflow_err(ovf), .branch_cnt(bcnt), .mispred_cnt(mcnt));

    branch_update_queue #(.entry_num(256), .fifo_depth(4), .cnt_width(2)) u_dut2 (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .branch_resolve_ex(res), .branch_idx_ex(idx),
        .branch_taken_ex(tkn), .branch_pred_ex(pred), .pred_valid_ex(pv), .predictor_hold(hold),
        .predictor_raddr(raddr), .stats_clr(clr), .upd_ready(upd_ready2), .predictor_wen(wen2),
        .predictor_waddr(waddr2), .predictor_wtaken(wtaken2), .raw_hazard(hazard2),
        .mispredict(misp2), .overflow_err(ovf2), .branch_cnt(bcnt2), .mispred_cnt(mcnt2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending records plus flags and counters.
    typedef struct packed { logic [7:0] idx; logic tkn; } ent_t;
    ent_t q[$];
    bit   m_misp, m_ovf;
    int   m_bc, m_mc, m_bc2, m_mc2;

    task automatic mreset();
        q.delete();
        m_misp = 0; m_ovf = 0;
        m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
    endtask

    // Check outputs against the model for the current inputs, then advance one edge.
    task automatic cycle();
        bit e_ready, e_wen, e_haz, push, mis;
        #1;
        e_ready = (q.size() != 4);
        e_wen   = (q.size() != 0) && !hold;
        e_haz   = 0;
        foreach (q[i]) if (q[i].idx == raddr) e_haz = 1;
        chk("upd_ready", upd_ready, e_ready);
        chk("wen", wen, e_wen);
        if (e_wen) begin
            chk("waddr", waddr, q[0].idx);
            chk("wtaken", wtaken, q[0].tkn);
        end
        chk("raw_hazard", hazard, e_haz);
        chk("mispredict", misp, m_misp);
        chk("overflow_err", ovf, m_ovf);
        chk("branch_cnt", bcnt, m_bc);
        chk("mispred_cnt", mcnt, m_mc);
        chk("branch_cnt_w2", bcnt2, m_bc2);
        chk("mispred_cnt_w2", mcnt2, m_mc2);
        push = res && e_ready;
        mis  = push && pv && (pred != tkn);
        if (e_wen) void'(q.pop_front());
        if (push) q.push_back('{idx: idx, tkn: tkn});
        if (res && !e_ready) m_ovf = 1;
        m_misp = mis;
        if (clr) begin
            m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
        end else begin
            if (push && m_bc  < 65535) m_bc++;
            if (mis  && m_mc  < 65535) m_mc++;
            if (push && m_bc2 < 3)     m_bc2++;
            if (mis  && m_mc2 < 3)     m_mc2++;
        end
        @(posedge cpu_clk); #1;
    endtask

    typedef struct {
        logic       res;
        logic [7:0] idx;
        logic       hold;
        logic       e_ready;
        logic       e_wen;
        logic [7:0] e_waddr;
        logic       e_ovf;
    } vec_t;
    vec_t tbl[10];

    int saved;

    initial begin
        // Fill-under-hold then drain, starting from an empty queue with no overflow.
        tbl[0] = '{1, 8'd1, 1, 1, 0, 8'd0, 0};
        tbl[1] = '{1, 8'd2, 1, 1, 0, 8'd0, 0};
        tbl[2] = '{1, 8'd3, 1, 1, 0, 8'd0, 0};
        tbl[3] = '{1, 8'd4, 1, 1, 0, 8'd0, 0};
        tbl[4] = '{1, 8'd5, 1, 0, 0, 8'd0, 0};
        tbl[5] = '{0, 8'd0, 0, 0, 1, 8'd1, 1};
        tbl[6] = '{0, 8'd0, 0, 1, 1, 8'd2, 1};
        tbl[7] = '{0, 8'd0, 0, 1, 1, 8'd3, 1};
        tbl[8] = '{0, 8'd0, 0, 1, 1, 8'd4, 1};
        tbl[9] = '{0, 8'd0, 0, 1, 0, 8'd0, 1};

        cpu_rstn = 0;
        {res, tkn, pred, pv, hold, clr} = '0;
        idx = 0; raddr = 0;
        mreset();
        #12;
        chk("rst_upd_ready", upd_ready, 1);
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wtaken", wtaken, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_mispredict", misp, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_branch_cnt", bcnt, 0);
        chk("rst_mispred_cnt", mcnt, 0);
        cpu_rstn = 1;
        @(posedge cpu_clk); #1;

        // Single resolve with a mispredict.
        res = 1; idx = 8'h12; tkn = 1; pred = 0; pv = 1;
        cycle();
        res = 0;
        #1;
        chk("t1_mispredict", misp, 1);
        chk("t1_wen", wen, 1);
        chk("t1_waddr", waddr, 8'h12);
        chk("t1_wtaken", wtaken, 1);
        cycle();
        chk("t1_branch_cnt", bcnt, 1);
        chk("t1_mispred_cnt", mcnt, 1);
        chk("t1_mispredict_low", misp, 0);
        cycle();

        // Table vectors.
        pv = 0;
        for (int i = 0; i < 10; i++) begin
            res = tbl[i].res; idx = tbl[i].idx; tkn = tbl[i].idx[0]; hold = tbl[i].hold;
            #1;
            chk($sformatf("tbl%0d_ready", i), upd_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_wen", i), wen, tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].e_waddr);
                chk($sformatf("tbl%0d_wtaken", i), wtaken, tbl[i].e_waddr[0]);
            end
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].e_ovf);
            cycle();
        end

        // Back-to-back stream across the pointer wrap; the queue never backs up.
        res = 1; hold = 0;
        for (int i = 0; i < 10; i++) begin
            idx = 8'(8'h80 + i); tkn = i[0];
            #1;
            chk("t3_ready", upd_ready, 1);
            cycle();
        end
        res = 0;
        cycle();

        // Hazard: live while queued and during the drain cycle, gone afterwards.
        raddr = 8'h40; idx = 8'h40; res = 1; hold = 1;
        cycle();
        res = 0;
        #1 chk("t4_hazard_queued", hazard, 1);
        hold = 0;
        #1 chk("t4_hazard_draining", hazard, 1);
        cycle();
        chk("t4_hazard_after", hazard, 0);
        raddr = 8'h41; idx = 8'h40; res = 1; hold = 1;
        cycle();
        res = 0;
        #1 chk("t4_hazard_other", hazard, 0);
        hold = 0;
        cycle();
        cycle();

        // Invalid prediction is not a mispredict; saturation; clear beats increment.
        saved = mcnt;
        res = 1; idx = 8'h33; tkn = 1; pred = 0; pv = 0;
        cycle();
        res = 0;
        #1;
        chk("t5_mispredict", misp, 0);
        chk("t5_mispred_cnt", mcnt, saved);
        chk("t5_cnt2_sat", bcnt2, 2'd3);
        cycle();
        res = 1; clr = 1; pv = 1;
        cycle();
        res = 0; clr = 0;
        #1;
        chk("t5_clr_bcnt", bcnt, 0);
        chk("t5_clr_mcnt", mcnt, 0);
        chk("t5_clr_bcnt2", bcnt2, 0);
        cycle();
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            res   = ($urandom_range(0, 9) < 7);
            idx   = 8'($urandom_range(0, 7));
            raddr = 8'($urandom_range(0, 7));
            tkn   = 1'($urandom);
            pred  = 1'($urandom);
            pv    = 1'($urandom);
            hold  = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 49) == 0);
            cycle();
        end
        {res, clr} = '0;

        // Asynchronous reset mid-drain.
        hold = 1; res = 1;
        for (int i = 0; i < 3; i++) begin
            idx = 8'(8'h21 + i); tkn = 1;
            cycle();
        end
        res = 0; hold = 0; raddr = 8'h22;
        #1 chk("t6_wen_before", wen, 1);
        #1 cpu_rstn = 0;
        #1;
        chk("t6_wen", wen, 0);
        chk("t6_ready", upd_ready, 1);
        chk("t6_hazard", hazard, 0);
        chk("t6_waddr", waddr, 0);
        chk("t6_mispredict", misp, 0);
        chk("t6_overflow", ovf, 0);
        chk("t6_branch_cnt", bcnt, 0);
        mreset();
        #1 cpu_rstn = 1;
        @(posedge cpu_clk); #1;
        for (int i = 0; i < 3; i++) cycle();
        res = 1; idx = 8'h55; tkn = 0; pv = 0;
        cycle();
        res = 0;
        #1 chk("t6_wen_new", wen, 1);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
